// File: rtl/bcd_countdown_timer.sv
// ============================================================================
// Module   : bcd_countdown_timer
// Brief    : Cascaded BCD countdown timer with preset, pause and optional
//            auto-reload on expiry.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bcd_countdown_timer #(
    parameter int               NDIG        = 2,
    parameter logic [4*NDIG-1:0] INIT       = {NDIG{4'h9}},
    parameter bit               AUTO_RELOAD = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic                load,
    input  logic [4*NDIG-1:0]   preset_in,
    input  logic                start,
    input  logic                pause,
    output logic [4*NDIG-1:0]   digits,
    output logic                running,
    output logic                expire,
    output logic                done
);

    localparam int WIDTH = 4 * NDIG;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_count;
    logic [WIDTH-1:0]   w_count_next;
    logic [WIDTH-1:0]   r_preset;
    logic [WIDTH-1:0]   w_preset_next;
    logic               w_expire_next;
    logic               r_running;
    logic               r_expire;
    logic               r_done;

    logic [WIDTH-1:0]   w_sanitised;
    logic [WIDTH-1:0]   w_decrement;
    logic [NDIG:0]      w_borrow;
    logic               w_zero;

    // Borrow ripples up from digit 0; a borrow out of the top digit means
    // every digit was zero, which doubles as the expiry detector.
    assign w_borrow[0] = 1'b1;
    assign w_zero      = w_borrow[NDIG];

    for (genvar g = 0; g < NDIG; g++) begin : g_digit
        logic [3:0] w_cur;
        logic [3:0] w_pin;

        assign w_cur = r_count[4*g +: 4];
        assign w_pin = preset_in[4*g +: 4];

        assign w_sanitised[4*g +: 4] = (w_pin > 4'd9) ? 4'd9 : w_pin;
        assign w_decrement[4*g +: 4] = !w_borrow[g]     ? w_cur :
                                       (w_cur == 4'd0)  ? 4'd9  :
                                                          w_cur - 4'd1;
        assign w_borrow[g+1] = w_borrow[g] && (w_cur == 4'd0);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_count   <= INIT;
            r_preset  <= INIT;
            r_running <= 1'b0;
            r_expire  <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_count   <= w_count_next;
            r_preset  <= w_preset_next;
            r_running <= (w_state_next == ST_RUN);
            r_expire  <= w_expire_next;
            r_done    <= (w_state_next == ST_DONE);
        end
    end

    // Priority: load > pause > start > tick.
    always_comb begin
        w_state_next  = r_state;
        w_count_next  = r_count;
        w_preset_next = r_preset;
        w_expire_next = 1'b0;

        if (load) begin
            w_preset_next = w_sanitised;
            w_count_next  = w_sanitised;
            w_state_next  = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!pause && start) w_state_next = ST_RUN;
                end
                ST_RUN: begin
                    if (pause) begin
                        w_state_next = ST_PAUSED;
                    end else if (tick) begin
                        if (w_zero) begin
                            w_expire_next = 1'b1;
                            if (AUTO_RELOAD) w_count_next = r_preset;
                            else             w_state_next = ST_DONE;
                        end else begin
                            w_count_next = w_decrement;
                        end
                    end
                end
                ST_PAUSED: begin
                    if (!pause && start) w_state_next = ST_RUN;
                end
                ST_DONE: begin
                    if (!pause && start) begin
                        w_count_next = r_preset;
                        w_state_next = ST_RUN;
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    assign digits  = r_count;
    assign running = r_running;
    assign expire  = r_expire;
    assign done    = r_done;

endmodule

`default_nettype wire
